// File: rtl/rtp_result_collector_if.sv
// Result-lane and output-stream bundle for rtp_result_collector.
// Handshake: a transfer happens on a cycle where valid && ready at the rising clock edge.
interface rtp_result_collector_if #(
    parameter int N_LANES = 2,
    parameter int ID_W    = 32,
    parameter int T_W     = 32
);
    localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    logic [N_LANES-1:0]      lane_valid;
    logic [N_LANES-1:0]      lane_ready;
    logic [N_LANES*ID_W-1:0] lane_ray_id;
    logic [N_LANES*T_W-1:0]  lane_hitT;
    logic                    out_valid;
    logic                    out_ready;
    logic [ID_W-1:0]         out_ray_id;
    logic [T_W-1:0]          out_hitT;
    logic [LANE_W-1:0]       out_lane;

    modport master (
        output lane_valid, lane_ray_id, lane_hitT, out_ready,
        input  lane_ready, out_valid, out_ray_id, out_hitT, out_lane
    );

    modport slave (
        input  lane_valid, lane_ray_id, lane_hitT, out_ready,
        output lane_ready, out_valid, out_ray_id, out_hitT, out_lane
    );
endinterface

// File: rtl/rtp_result_collector.sv
// Multi-lane ray result collector: round-robin arbitration into a FWFT FIFO,
// run tracking against an expected ray count, and cycle/stall/result counters.
module rtp_result_collector #(
    parameter int          N_LANES = 2,
    parameter int          ID_W    = 32,
    parameter int          T_W     = 32,
    parameter int          DEPTH   = 16,
    parameter int          CNT_W   = 64,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          expected_rays,
    rtp_result_collector_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_W-1:0]     total_cycle,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [31:0]          result_count,
    output logic [1:0]           state_dbg
);
    localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int AW     = $clog2(DEPTH);
    localparam int ENT_W  = LANE_W + ID_W + T_W;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t             state, state_next;
    logic [31:0]        expected_q;
    logic [31:0]        idle_cnt;
    logic [LANE_W-1:0]  rr_ptr, grant_idx;
    logic [N_LANES-1:0] grant;
    logic               grant_any;
    logic [ENT_W-1:0]   mem [DEPTH];
    logic [ENT_W-1:0]   head, push_data;
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic               full, empty, push, pop, start_ok, timed_out;
    int                 idx;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign start_ok = start && (state == IDLE || state == DONE);
    assign push     = grant_any;
    assign pop      = !empty && bus.out_ready;

    // Round-robin: first valid lane at or after rr_ptr; full is the registered occupancy.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant     = '0;
        idx       = 0;
        if (state == RUN && !full) begin
            for (int k = 0; k < N_LANES; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N_LANES) idx = idx - N_LANES;
                if (!grant_any && bus.lane_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = LANE_W'(idx);
                end
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    assign bus.lane_ready = grant;
    assign push_data = {grant_idx,
                        bus.lane_ray_id[int'(grant_idx)*ID_W +: ID_W],
                        bus.lane_hitT[int'(grant_idx)*T_W +: T_W]};

    always_comb begin
        state_next = state;
        timed_out  = 1'b0;
        case (state)
            IDLE, DONE: if (start) state_next = (expected_rays == '0) ? DONE : RUN;
            RUN: begin
                if (push && (result_count + 32'd1 == expected_q)) begin
                    state_next = DRAIN;
                end else if (TIMEOUT != 0 && !push && idle_cnt == 32'(TIMEOUT - 1)) begin
                    state_next = DONE;
                    timed_out  = 1'b1;
                end
            end
            DRAIN: if (empty) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            expected_q   <= '0;
            idle_cnt     <= '0;
            rr_ptr       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            timeout      <= 1'b0;
            total_cycle  <= '0;
            stall_cycles <= '0;
            result_count <= '0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                expected_q   <= expected_rays;
                idle_cnt     <= '0;
                timeout      <= 1'b0;
                total_cycle  <= '0;
                stall_cycles <= '0;
                result_count <= '0;
            end else begin
                if ((state == RUN || state == DRAIN) && total_cycle != '1)
                    total_cycle <= total_cycle + 1'b1;
                if (state == RUN && |bus.lane_valid && !push && stall_cycles != '1)
                    stall_cycles <= stall_cycles + 1'b1;
                if (push) result_count <= result_count + 32'd1;
                if (timed_out) timeout <= 1'b1;
                if (TIMEOUT != 0 && state == RUN)
                    idle_cnt <= push ? '0 : idle_cnt + 32'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (int'(grant_idx) == N_LANES - 1) ? '0 : grant_idx + LANE_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage carries no reset; outputs are gated by occupancy instead.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head           = mem[rd_ptr];
    assign bus.out_valid  = !empty;
    assign bus.out_lane   = empty ? '0 : head[ENT_W-1 -: LANE_W];
    assign bus.out_ray_id = empty ? '0 : head[T_W +: ID_W];
    assign bus.out_hitT   = empty ? '0 : head[T_W-1:0];
    assign busy           = (state == RUN) || (state == DRAIN);
    assign done           = (state == DONE);
    assign state_dbg      = state;
endmodule
